// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control sequencer for the MIPS core.
// Walks each instruction through FETCH/DECODE/EXEC/[MEM]/[WB], handshakes with
// instruction and data memory, flags illegal encodings and memory timeouts,
// and counts retired instructions.
module mc_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic [31:0]      Ins,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             IR_we,
  output logic             PC_we,
  output logic             MDR_we,
  output logic             RF_we,
  output logic [1:0]       RegDst,
  output logic [1:0]       WB_sel,
  output logic [2:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_IDLE   = 3'd5,
    S_ERR    = 3'd7
  } state_t;

  // Instruction class, enough to steer the sequence after DECODE.
  typedef enum logic [2:0] {
    C_ILL  = 3'd0,
    C_BR   = 3'd1,  // J, JR, BEQ, BNE: finish in EXEC
    C_LW   = 3'd2,
    C_SW   = 3'd3,
    C_RALU = 3'd4,
    C_IALU = 3'd5,
    C_JAL  = 3'd6,
    C_JALR = 3'd7
  } cls_t;

  state_t            state_q, state_d;
  cls_t              cls_q, cls_d, cls_dec;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              retire;

  // Only opcode and funct matter for sequencing; register/immediate fields do not.
  logic unused_ins;
  assign unused_ins = ^Ins[25:6];

  function automatic cls_t classify(input logic [31:0] ins);
    cls_t c;
    c = C_ILL;
    case (ins[31:26])
      6'd0: begin
        case (ins[5:0])
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
          6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: c = C_RALU;
          6'h08:                             c = C_BR;
          6'h09:                             c = C_JALR;
          default:                           c = C_ILL;
        endcase
      end
      6'd2, 6'd4, 6'd5:                       c = C_BR;
      6'd3:                                   c = C_JAL;
      6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14: c = C_IALU;
      6'd35:                                  c = C_LW;
      6'd43:                                  c = C_SW;
      default:                                c = C_ILL;
    endcase
    return c;
  endfunction

  // Decode the instruction register contents for the DECODE step.
  always_comb begin
    cls_dec = classify(Ins);
  end

  // Next-state, wait counter and all control outputs; outputs depend only on
  // the current state (plus the ack inputs), so reset drops them immediately.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    wait_d    = '0;
    retire    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    IR_we     = 1'b0;
    PC_we     = 1'b0;
    MDR_we    = 1'b0;
    RF_we     = 1'b0;
    RegDst    = 2'd0;
    WB_sel    = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        IR_we    = imem_ack;
        if (imem_ack)               state_d = S_DECODE;
        else if (wait_q == WAIT_LAST) state_d = S_ERR;
        else                        wait_d  = wait_q + WAIT_W'(1);
      end
      S_DECODE: begin
        cls_d   = cls_dec;
        state_d = (cls_dec == C_ILL) ? S_ERR : S_EXEC;
      end
      S_EXEC: begin
        PC_we = 1'b1;
        case (cls_q)
          C_BR: begin
            retire  = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
          end
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_SW);
        if (dmem_ack) begin
          MDR_we = (cls_q == C_LW);
          if (cls_q == C_SW) begin
            retire  = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        RF_we   = 1'b1;
        retire  = 1'b1;
        state_d = run ? S_FETCH : S_IDLE;
        case (cls_q)
          C_RALU:  begin RegDst = 2'd1; WB_sel = 2'd0; end
          C_LW:    begin RegDst = 2'd0; WB_sel = 2'd1; end
          C_JAL:   begin RegDst = 2'd2; WB_sel = 2'd2; end
          C_JALR:  begin RegDst = 2'd1; WB_sel = 2'd2; end
          default: begin RegDst = 2'd0; WB_sel = 2'd0; end
        endcase
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  // Retire counter advances on the cycle an instruction leaves its last state.
  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + CNT_W'(1);
  end

  // State, class, wait counter and retire count registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ILL;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign err     = (state_q == S_ERR);
  assign retired = retired_q;

endmodule
